// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment scanner with per-switch blanking.
// Digits come from a frame shadow that is refreshed only at frame wrap or enable.
module seg_scan #(
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_1KHz,
    input  logic        en,
    input  logic [23:0] data,
    input  logic [5:0]  dp_en,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);
    localparam int CW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;

    typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [2:0]    idx_next;
    logic          wrap;
    logic [CW-1:0] cnt;
    logic [23:0]   shadow_data;
    logic [5:0]    shadow_dp;
    logic          sync1;
    logic          sync2;
    logic          hist;
    logic          primed;
    logic          armed;
    logic          tick;
    logic [3:0]    digit;
    logic          digit_dp;

    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 8'hC0;
            4'h1: glyph = 8'hF9;
            4'h2: glyph = 8'hA4;
            4'h3: glyph = 8'hB0;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h92;
            4'h6: glyph = 8'h82;
            4'h7: glyph = 8'hF8;
            4'h8: glyph = 8'h80;
            4'h9: glyph = 8'h90;
            4'hA: glyph = 8'h88;
            4'hB: glyph = 8'h83;
            4'hC: glyph = 8'hC6;
            4'hD: glyph = 8'hA1;
            4'hE: glyph = 8'h86;
            default: glyph = 8'h8E;
        endcase
    endfunction

    // armed only sets once a genuine low sample has been taken after reset,
    // so a clk_1KHz that is already high at release cannot fake a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            hist   <= 1'b0;
            primed <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1  <= clk_1KHz;
            sync2  <= sync1;
            hist   <= sync2;
            primed <= 1'b1;
            armed  <= armed | (primed & ~sync1);
        end
    end

    assign tick = sync2 & ~hist & armed;

    always_comb begin
        idx_next = (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
        wrap     = (idx_next == 3'd0);
    end

    always_comb begin
        digit    = '0;
        digit_dp = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (idx == 3'(i)) begin
                digit    = shadow_data[4*i +: 4];
                digit_dp = shadow_dp[i];
            end
        end
    end

    // Outputs are registered from the current state, and blank at once when en drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= OFF;
            idx         <= '0;
            cnt         <= '0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            sel         <= 6'h3F;
            seg         <= 8'hFF;
        end else begin
            if (!en || state != SHOW) begin
                sel <= 6'h3F;
                seg <= 8'hFF;
            end else begin
                sel <= ~(6'b000001 << idx);
                seg <= glyph(digit) & {~digit_dp, 7'h7F};
            end

            if (!en) begin
                state <= OFF;
                idx   <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    OFF: begin
                        idx         <= '0;
                        cnt         <= '0;
                        shadow_data <= data;
                        shadow_dp   <= dp_en;
                        state       <= (BLANK_CYC == 0) ? SHOW : BLANK;
                    end
                    BLANK: begin
                        if (tick) begin
                            idx <= idx_next;
                            cnt <= '0;
                            if (wrap) begin
                                shadow_data <= data;
                                shadow_dp   <= dp_en;
                            end
                        end else if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= SHOW;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    SHOW: begin
                        if (tick) begin
                            idx   <= idx_next;
                            cnt   <= '0;
                            state <= (BLANK_CYC == 0) ? SHOW : BLANK;
                            if (wrap) begin
                                shadow_data <= data;
                                shadow_dp   <= dp_en;
                            end
                        end
                    end
                    default: begin
                        state <= OFF;
                        idx   <= '0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
